lcd_read_controller: RTL and testbench

//  Read-side companion of the CFAH1602B write path on the DE2i-150. Runs one HD44780-style read

---
 rtl/lcd_read_controller.sv | 109 ++++++++++
 tb/tb_lcd_read_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_read_controller.sv
// HD44780-style LCD read cycle engine: one RW=1/EN strobe returning DDRAM data or BF/address,
// with an optional busy-flag poll loop that ends on BF=0 or after POLL_MAX reads.
module lcd_read_controller #(
   parameter int SETUP_CYC   = 2,
   parameter int EN_HIGH_CYC = 16,
   parameter int HOLD_CYC    = 2,
   parameter int POLL_GAP    = 4,
   parameter int POLL_MAX    = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       iRS,
   input  logic       iPOLL,
   input  logic [7:0] LCD_DATA_IN,
   output logic       LCD_EN,
   output logic       LCD_RW,
   output logic       LCD_RS,
   output logic [7:0] RD_DATA,
   output logic       RD_VALID,
   output logic       TIMEOUT,
   output logic       BUSY
);

   localparam int M1 = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
   localparam int M2 = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
   localparam int M3 = (M2 > POLL_GAP) ? M2 : POLL_GAP;
   localparam int CW = $clog2(M3 + 1);
   localparam int PW = $clog2(POLL_MAX + 1);

   localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] EN_LAST    = CW'(EN_HIGH_CYC - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(POLL_GAP - 1);
   localparam logic [PW-1:0] CNT_MAX    = PW'(POLL_MAX);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_GAP, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cyc_q;
   logic [PW-1:0] cnt_q;
   logic          rs_q, poll_q, to_q;
   logic [7:0]    rd_q;
   logic          sample;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SETUP;
         S_SETUP: if (cyc_q == SETUP_LAST) state_d = S_EN_HI;
         S_EN_HI: if (cyc_q == EN_LAST) state_d = S_HOLD;
         S_HOLD:
            if (cyc_q == HOLD_LAST) begin
               if (poll_q && rd_q[7] && (cnt_q != CNT_MAX)) state_d = S_GAP;
               else                                         state_d = S_DONE;
            end
         S_GAP:   if (cyc_q == GAP_LAST) state_d = S_SETUP;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign sample = (state_q == S_EN_HI) && (cyc_q == EN_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_q  <= '0;
         cnt_q  <= '0;
         rs_q   <= 1'b0;
         poll_q <= 1'b0;
         to_q   <= 1'b0;
         rd_q   <= 8'h00;
      end else begin
         if (state_d != state_q || state_q == S_IDLE) cyc_q <= '0;
         else                                         cyc_q <= cyc_q + 1'b1;

         if (state_q == S_IDLE && start) begin
            rs_q   <= iRS & ~iPOLL;  // busy-flag polls always read the instruction register
            poll_q <= iPOLL;
            cnt_q  <= '0;
            to_q   <= 1'b0;
         end

         if (sample) begin
            rd_q <= LCD_DATA_IN;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
         end

         if (state_q == S_HOLD && state_d == S_DONE)
            to_q <= poll_q & rd_q[7];
      end
   end

   always_comb begin
      LCD_EN   = (state_q == S_EN_HI);
      LCD_RW   = (state_q == S_SETUP) || (state_q == S_EN_HI) || (state_q == S_HOLD);
      LCD_RS   = LCD_RW & rs_q;
      BUSY     = LCD_RW || (state_q == S_GAP);
      RD_DATA  = rd_q;
      RD_VALID = (state_q == S_DONE) && !to_q;
      TIMEOUT  = (state_q == S_DONE) &&  to_q;
   end

endmodule

// File: tb/tb_lcd_read_controller.sv
// Directed bench for lcd_read_controller: a default instance plus a POLL_MAX=3 instance for timeout.
module tb_lcd_read_controller;

   logic       clk = 1'b0;
   logic       reset, start_a, start_b, iRS, iPOLL;
   logic [7:0] bus;
   logic       en_a, rw_a, rs_a, vld_a, to_a, busy_a;
   logic       en_b, rw_b, rs_b, vld_b, to_b, busy_b;
   logic [7:0] rdd_a, rdd_b;

   logic       sel;
   logic       en_s, rw_s, rs_s, vld_s, to_s, busy_s;
   logic [7:0] rdd_s;
   logic       prev_en, prev_rs, prev_rw;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lcd_read_controller dut_a (
      .clk(clk), .reset(reset), .start(start_a), .iRS(iRS), .iPOLL(iPOLL), .LCD_DATA_IN(bus),
      .LCD_EN(en_a), .LCD_RW(rw_a), .LCD_RS(rs_a), .RD_DATA(rdd_a), .RD_VALID(vld_a),
      .TIMEOUT(to_a), .BUSY(busy_a));

   lcd_read_controller #(.POLL_MAX(3)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .iRS(iRS), .iPOLL(iPOLL), .LCD_DATA_IN(bus),
      .LCD_EN(en_b), .LCD_RW(rw_b), .LCD_RS(rs_b), .RD_DATA(rdd_b), .RD_VALID(vld_b),
      .TIMEOUT(to_b), .BUSY(busy_b));

   assign en_s   = sel ? en_b   : en_a;
   assign rw_s   = sel ? rw_b   : rw_a;
   assign rs_s   = sel ? rs_b   : rs_a;
   assign vld_s  = sel ? vld_b  : vld_a;
   assign to_s   = sel ? to_b   : to_a;
   assign busy_s = sel ? busy_b : busy_a;
   assign rdd_s  = sel ? rdd_b  : rdd_a;

   typedef struct {
      logic       rs;
      logic       poll;
      logic [7:0] bus;
      logic       exp_rs;
      logic [7:0] exp_data;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic inv_check();
      chk("en_without_rw", 32'(en_s & ~rw_s), 0);
      chk("valid_and_timeout", 32'(vld_s & to_s), 0);
      chk("rsrw_change_while_en", 32'(prev_en & en_s & ((rs_s ^ prev_rs) | (rw_s ^ prev_rw))), 0);
      chk("busy_with_pulse", 32'(busy_s & (vld_s | to_s)), 0);
      prev_en = en_s;
      prev_rs = rs_s;
      prev_rw = rw_s;
   endtask

   // Runs one transaction on the selected instance, counting strobes, gaps and result pulses.
   task automatic txn(input logic b, input logic rs, input logic poll, input logic [7:0] b0,
                      input logic [7:0] b1, input int sw, input logic exp_rs,
                      output int lat, output int np, output int nen, output int ngap,
                      output int nv, output int nt, output int nrs,
                      output logic [7:0] data, output logic busy_after);
      logic done;
      sel = b; bus = b0; iRS = rs; iPOLL = poll;
      prev_en = 0; prev_rs = 0; prev_rw = 0;
      lat = -1; np = 0; nen = 0; ngap = 0; nv = 0; nt = 0; nrs = 0; data = 8'hxx;
      if (b) start_b = 1'b1; else start_a = 1'b1;
      for (int c = 1; c <= 5000; c++) begin
         @(negedge clk);
         start_a = 1'b0; start_b = 1'b0;
         if (en_s && !prev_en) np++;
         if (en_s) nen++;
         if (busy_s && !rw_s) ngap++;
         if (rw_s && rs_s !== exp_rs) nrs++;
         if (np >= sw && !en_s) bus = b1;
         done = vld_s | to_s;
         if (done) begin
            nv = int'(vld_s); nt = int'(to_s); lat = c; data = rdd_s;
         end
         inv_check();
         if (done) break;
      end
      @(negedge clk);
      busy_after = busy_s;
      nv += int'(vld_s);
      nt += int'(to_s);
   endtask

   int         lat, np, nen, ngap, nv, nt, nrs;
   logic [7:0] data;
   logic       busy_after;
   int         pulses;
   int         ptime [4];

   initial begin
      tbl[0] = '{rs: 1'b1, poll: 1'b0, bus: 8'h41, exp_rs: 1'b1, exp_data: 8'h41};
      tbl[1] = '{rs: 1'b0, poll: 1'b0, bus: 8'h0F, exp_rs: 1'b0, exp_data: 8'h0F};
      tbl[2] = '{rs: 1'b1, poll: 1'b0, bus: 8'hFF, exp_rs: 1'b1, exp_data: 8'hFF};
      tbl[3] = '{rs: 1'b0, poll: 1'b0, bus: 8'h80, exp_rs: 1'b0, exp_data: 8'h80};
      tbl[4] = '{rs: 1'b1, poll: 1'b1, bus: 8'h05, exp_rs: 1'b0, exp_data: 8'h05};

      reset = 1'b0; start_a = 0; start_b = 0; iRS = 0; iPOLL = 0; bus = 8'h00; sel = 0;
      repeat (3) @(negedge clk);
      chk("reset_en",    32'(en_a),    0);
      chk("reset_rw",    32'(rw_a),    0);
      chk("reset_rs",    32'(rs_a),    0);
      chk("reset_data",  32'(rdd_a),   0);
      chk("reset_valid", 32'(vld_a),   0);
      chk("reset_to",    32'(to_a),    0);
      chk("reset_busy",  32'(busy_a),  0);
      reset = 1'b1;
      @(negedge clk);

      // Single reads (and a poll that clears on its first read)
      foreach (tbl[i]) begin
         txn(1'b0, tbl[i].rs, tbl[i].poll, tbl[i].bus, tbl[i].bus, 99, tbl[i].exp_rs,
             lat, np, nen, ngap, nv, nt, nrs, data, busy_after);
         chk($sformatf("v%0d_latency", i), 32'(lat), 21);
         chk($sformatf("v%0d_en_cycles", i), 32'(nen), 16);
         chk($sformatf("v%0d_en_pulses", i), 32'(np), 1);
         chk($sformatf("v%0d_gap", i), 32'(ngap), 0);
         chk($sformatf("v%0d_rs_wrong", i), 32'(nrs), 0);
         chk($sformatf("v%0d_valid", i), 32'(nv), 1);
         chk($sformatf("v%0d_timeout", i), 32'(nt), 0);
         chk($sformatf("v%0d_data", i), 32'(data), 32'(tbl[i].exp_data));
         chk($sformatf("v%0d_busy_after", i), 32'(busy_after), 0);
         chk($sformatf("v%0d_data_hold", i), 32'(rdd_a), 32'(tbl[i].exp_data));
      end

      // Poll: BF=1 for three reads, then clear
      txn(1'b0, 1'b0, 1'b1, 8'h85, 8'h05, 3, 1'b0, lat, np, nen, ngap, nv, nt, nrs, data, busy_after);
      chk("poll_latency", 32'(lat), 93);
      chk("poll_en_pulses", 32'(np), 4);
      chk("poll_en_cycles", 32'(nen), 64);
      chk("poll_gap_cycles", 32'(ngap), 12);
      chk("poll_valid", 32'(nv), 1);
      chk("poll_timeout", 32'(nt), 0);
      chk("poll_data", 32'(data), 32'h05);
      chk("poll_busy_after", 32'(busy_after), 0);

      // Poll timeout on the POLL_MAX=3 instance
      txn(1'b1, 1'b1, 1'b1, 8'h80, 8'h80, 99, 1'b0, lat, np, nen, ngap, nv, nt, nrs, data, busy_after);
      chk("tmo_latency", 32'(lat), 69);
      chk("tmo_en_pulses", 32'(np), 3);
      chk("tmo_gap_cycles", 32'(ngap), 8);
      chk("tmo_valid", 32'(nv), 0);
      chk("tmo_timeout", 32'(nt), 1);
      chk("tmo_data", 32'(data), 32'h80);
      chk("tmo_rs_wrong", 32'(nrs), 0);
      chk("tmo_busy_after", 32'(busy_after), 0);

      // Reset in the middle of the EN-high phase
      sel = 0; iRS = 1'b1; iPOLL = 1'b0; bus = 8'h41;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (7) @(negedge clk);
      chk("mid_en_before_reset", 32'(en_a), 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_reset_en",   32'(en_a),   0);
      chk("mid_reset_rw",   32'(rw_a),   0);
      chk("mid_reset_busy", 32'(busy_a), 0);
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         pulses += int'(vld_a) + int'(to_a) + int'(busy_a);
      end
      chk("mid_reset_quiet", 32'(pulses), 0);
      reset = 1'b1;
      @(negedge clk);
      txn(1'b0, 1'b1, 1'b0, 8'h5A, 8'h5A, 99, 1'b1, lat, np, nen, ngap, nv, nt, nrs, data, busy_after);
      chk("post_reset_latency", 32'(lat), 21);
      chk("post_reset_en_cycles", 32'(nen), 16);
      chk("post_reset_data", 32'(data), 32'h5A);
      chk("post_reset_valid", 32'(nv), 1);

      // start held high: back-to-back transactions, 22 cycles apart
      sel = 0; iRS = 1'b0; iPOLL = 1'b0; bus = 8'h33;
      prev_en = 0; prev_rs = 0; prev_rw = 0;
      pulses = 0;
      start_a = 1'b1;
      for (int c = 1; c <= 87; c++) begin
         @(negedge clk);
         if (c >= 80) start_a = 1'b0;
         if (vld_a) begin
            if (pulses < 4) ptime[pulses] = c;
            pulses++;
         end
         inv_check();
      end
      chk("b2b_pulses", 32'(pulses), 4);
      chk("b2b_t0", 32'(ptime[0]), 21);
      chk("b2b_t1", 32'(ptime[1]), 43);
      chk("b2b_t2", 32'(ptime[2]), 65);
      chk("b2b_t3", 32'(ptime[3]), 87);
      chk("b2b_data", 32'(rdd_a), 32'h33);
      @(negedge clk);
      chk("b2b_busy_after", 32'(busy_a), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
